trimux_sched: RTL and testbench

//  Packing scheduler for the trimux slot crossbar. Accepts batches of element

---
 rtl/trimux_sched.sv | 117 +++++++++++
 tb/tb_trimux_sched.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/trimux_sched.sv
// trimux_sched: packs whole element descriptors into BS-slot beats and emits
// per-beat crossbar control (count, lengths, offsets, prefix-sum slot ends).
module trimux_sched #(
    parameter int VLEN = 256,
    parameter int BSW  = 5,
    localparam int BS  = 1 << BSW,
    localparam int WW  = $clog2(VLEN) - BSW + 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [BSW:0]   in_num,
    input  logic [WW-1:0]  in_len [BS],
    input  logic [BSW-1:0] in_pos [BS],
    input  logic           in_flush,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [BSW:0]   out_inum,
    output logic [WW-1:0]  out_ilen [BS],
    output logic [BSW-1:0] out_ipos [BS],
    output logic [BSW:0]   out_psum [BS],
    output logic [BSW:0]   out_fill
);
    localparam logic [BSW:0] FULL = (BSW + 1)'(BS);
    localparam logic [BSW:0] ONE  = (BSW + 1)'(1);

    typedef enum logic [1:0] {IDLE, PACK, EMIT} state_t;

    state_t         r_state, w_next;
    logic [WW-1:0]  r_len [BS];
    logic [BSW-1:0] r_pos [BS];
    logic [BSW:0]   r_num, r_cursor, r_cnt, r_fill;
    logic           r_flush;
    logic [WW-1:0]  r_ilen [BS];
    logic [BSW-1:0] r_ipos [BS];
    logic [BSW:0]   r_psum [BS];

    logic [BSW-1:0] w_e;
    logic [WW-1:0]  w_l;
    logic [BSW:0]   w_sum, w_cnt1, w_cur1;
    logic           w_fit, w_take, w_clear;

    // fill <= BS and L < BS, so the sum never exceeds BSW+1 bits
    assign w_e     = r_cursor[BSW-1:0];
    assign w_l     = r_len[w_e];
    assign w_sum   = r_fill + (BSW + 1)'(w_l);
    assign w_fit   = w_sum <= FULL;
    assign w_cnt1  = r_cnt + ONE;
    assign w_cur1  = r_cursor + ONE;
    assign w_take  = r_state == PACK && w_fit;
    assign w_clear = r_state == EMIT && out_ready;

    always_ff @(posedge clk)
        r_state <= rst ? IDLE : w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (in_valid) w_next = |in_num ? PACK : (in_flush && |r_cnt) ? EMIT : IDLE;
            PACK: w_next = (!w_fit || w_sum == FULL || w_cnt1 == FULL) ? EMIT :
                           w_cur1 != r_num ? PACK : r_flush ? EMIT : IDLE;
            EMIT: if (out_ready) w_next = r_cursor < r_num ? PACK : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = r_state == IDLE;
        out_valid = r_state == EMIT;
    end

    assign out_inum = r_cnt;
    assign out_fill = r_fill;
    assign out_ilen = r_ilen;
    assign out_ipos = r_ipos;
    assign out_psum = r_psum;

    // open beat: cleared on reset or when the crossbar takes it, so unused slots read 0
    always_ff @(posedge clk) begin
        if (rst || w_clear) begin
            r_cnt  <= '0;
            r_fill <= '0;
            for (int i = 0; i < BS; i++) begin
                r_ilen[i] <= '0;
                r_ipos[i] <= '0;
                r_psum[i] <= '0;
            end
        end else if (w_take) begin
            r_ilen[r_cnt[BSW-1:0]] <= w_l;
            r_ipos[r_cnt[BSW-1:0]] <= r_pos[w_e];
            r_psum[r_cnt[BSW-1:0]] <= w_sum;
            r_cnt  <= w_cnt1;
            r_fill <= w_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_num    <= '0;
            r_flush  <= 1'b0;
            r_cursor <= '0;
            for (int i = 0; i < BS; i++) begin
                r_len[i] <= '0;
                r_pos[i] <= '0;
            end
        end else if (r_state == IDLE && in_valid) begin
            r_num    <= in_num;
            r_flush  <= in_flush;
            r_cursor <= '0;
            r_len    <= in_len;
            r_pos    <= in_pos;
        end else if (w_take) begin
            r_cursor <= w_cur1;
        end
    end
endmodule

// File: tb/tb_trimux_sched.sv
// tb_trimux_sched: scoreboard bench; a reference packer predicts every beat
// when a batch is accepted, and the monitor compares each consumed beat.
module tb_trimux_sched;
    localparam int BSW = 5;
    localparam int BS  = 1 << BSW;
    localparam int WW  = 8 - BSW + 1;

    typedef logic [BS-1:0][WW-1:0]  lens_t;
    typedef logic [BS-1:0][BSW-1:0] poss_t;
    typedef logic [BS-1:0][BSW:0]   psum_t;

    typedef struct packed {
        logic [BSW:0] inum;
        logic [BSW:0] fill;
        lens_t        ilen;
        poss_t        ipos;
        psum_t        psum;
    } beat_t;

    logic           clk = 0, rst = 1, in_valid = 0, in_flush = 0, out_ready = 0;
    logic [BSW:0]   in_num = '0;
    logic [WW-1:0]  in_len [BS];
    logic [BSW-1:0] in_pos [BS];
    logic           in_ready, out_valid;
    logic [BSW:0]   out_inum, out_fill;
    logic [WW-1:0]  out_ilen [BS];
    logic [BSW-1:0] out_ipos [BS];
    logic [BSW:0]   out_psum [BS];

    lens_t o_ilen;
    poss_t o_ipos;
    psum_t o_psum;

    int n_chk = 0, n_fail = 0, cyc = 0, n_beats = 0, t_last = 0, t_prev = 0;
    logic or_rand = 0, or_val = 1;
    beat_t q[$];
    int m_cnt = 0, m_fill = 0;
    lens_t m_ilen = '0;
    poss_t m_ipos = '0;
    psum_t m_psum = '0;

    trimux_sched #(.VLEN(256), .BSW(BSW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_num(in_num), .in_len(in_len), .in_pos(in_pos), .in_flush(in_flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_inum(out_inum),
        .out_ilen(out_ilen), .out_ipos(out_ipos), .out_psum(out_psum), .out_fill(out_fill)
    );

    always #5 clk = ~clk;

    always_comb
        for (int i = 0; i < BS; i++) begin
            o_ilen[i] = out_ilen[i];
            o_ipos[i] = out_ipos[i];
            o_psum[i] = out_psum[i];
        end

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic close_beat;
        beat_t b;
        b.inum = (BSW + 1)'(m_cnt);
        b.fill = (BSW + 1)'(m_fill);
        b.ilen = m_ilen;
        b.ipos = m_ipos;
        b.psum = m_psum;
        q.push_back(b);
        m_cnt = 0; m_fill = 0; m_ilen = '0; m_ipos = '0; m_psum = '0;
    endtask

    task automatic model(input int num, input lens_t lens, input poss_t poss, input logic fl);
        for (int e = 0; e < num; e++) begin
            if (m_fill + int'(lens[e]) > BS) close_beat();
            m_ilen[m_cnt] = lens[e];
            m_ipos[m_cnt] = poss[e];
            m_fill += int'(lens[e]);
            m_psum[m_cnt] = (BSW + 1)'(m_fill);
            m_cnt++;
            if (m_fill == BS || m_cnt == BS) close_beat();
        end
        if (fl && m_cnt > 0) close_beat();
    endtask

    task automatic send(input int num, input lens_t lens, input poss_t poss, input logic fl);
        int n = 0;
        while (!in_ready && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check("accept_timeout", 192'(in_ready), 192'(1));
        in_valid = 1;
        in_num = (BSW + 1)'(num);
        in_flush = fl;
        for (int i = 0; i < BS; i++) begin
            in_len[i] = lens[i];
            in_pos[i] = poss[i];
        end
        @(posedge clk); #1;
        in_valid = 0;
        model(num, lens, poss, fl);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("valid_timeout", 192'(out_valid), 192'(1));
    endtask

    task automatic wait_idle;
        int n = 0;
        @(negedge clk);
        while (!(in_ready && !out_valid && q.size() == 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain", 192'(in_ready && !out_valid && q.size() == 0), 192'(1));
    endtask

    initial begin
        out_ready = 0;
        forever begin
            @(posedge clk); #1;
            out_ready = or_rand ? 1'($urandom_range(0, 1)) : or_val;
        end
    end

    always @(negedge clk) begin
        beat_t b;
        cyc++;
        if (out_valid && out_ready) begin
            check("sb_has_beat", 192'(q.size() != 0), 192'(1));
            if (q.size() != 0) begin
                b = q.pop_front();
                check("inum", 192'(out_inum), 192'(b.inum));
                check("fill", 192'(out_fill), 192'(b.fill));
                check("ilen", 192'(o_ilen), 192'(b.ilen));
                check("ipos", 192'(o_ipos), 192'(b.ipos));
                check("psum", 192'(o_psum), 192'(b.psum));
            end
            n_beats++;
            t_prev = t_last;
            t_last = cyc;
        end
    end

    initial begin
        lens_t l;
        poss_t p;
        int n, nb;
        for (int i = 0; i < BS; i++) begin
            in_len[i] = '0;
            in_pos[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("rst_in_ready", 192'(in_ready), 192'(1));
        check("rst_out_valid", 192'(out_valid), 192'(0));
        check("rst_inum", 192'(out_inum), 192'(0));
        check("rst_psum", 192'(o_psum), 192'(0));

        l = '0; p = '0;
        for (int i = 0; i < 4; i++) begin
            l[i] = WW'(8);
            p[i] = BSW'(i * 3);
        end
        send(4, l, p, 0);
        wait_valid(n);
        check("t1_latency", 192'(n), 192'(4));
        check("t1_fill", 192'(out_fill), 192'(32));
        check("t1_psum3", 192'(o_psum[3]), 192'(32));
        wait_idle();
        check("t1_cnt_after", 192'(out_inum), 192'(0));

        l = '0; p = '0;
        for (int i = 0; i < 3; i++) begin
            l[i] = WW'(15);
            p[i] = BSW'(i + 1);
        end
        nb = n_beats;
        send(3, l, p, 1);
        wait_idle();
        check("t2_beats", 192'(n_beats - nb), 192'(2));
        check("t2_gap", 192'(t_last - t_prev), 192'(2));

        l = '0; p = '0; l[0] = WW'(5); p[0] = BSW'(3);
        send(1, l, p, 0);
        wait_idle();
        l[0] = WW'(7); p[0] = BSW'(9);
        send(1, l, p, 1);
        wait_valid(n);
        check("t3_inum", 192'(out_inum), 192'(2));
        check("t3_ipos1", 192'(o_ipos[1]), 192'(9));
        wait_idle();

        or_val = 0;
        l = '0; p = '0; l[0] = WW'(10); l[1] = WW'(10); p[1] = BSW'(17);
        send(2, l, p, 1);
        wait_valid(n);
        check("t4_sb_front", 192'(q.size() != 0), 192'(1));
        for (int k = 0; k < 5 && q.size() != 0; k++) begin
            check("t4_hold_valid", 192'(out_valid), 192'(1));
            check("t4_hold_ready", 192'(in_ready), 192'(0));
            check("t4_hold_psum", 192'(o_psum), 192'(q[0].psum));
            @(negedge clk);
        end
        or_val = 1;
        l = '0; p = '0; l[0] = WW'(6); p[0] = BSW'(30);
        send(1, l, p, 1);
        wait_idle();

        l = '0; p = '0; l[1] = WW'(4); p[0] = BSW'(1); p[1] = BSW'(2); p[2] = BSW'(4);
        send(3, l, p, 1);
        wait_valid(n);
        check("t5_psum", 192'(o_psum[2:0]), 192'({6'd4, 6'd4, 6'd0}));
        check("t5_fill", 192'(out_fill), 192'(4));
        wait_idle();
        nb = n_beats;
        send(0, '0, '0, 1);
        repeat (5) @(negedge clk);
        check("t5_no_empty_beat", 192'(n_beats - nb), 192'(0));
        check("t5_no_valid", 192'(out_valid), 192'(0));

        l = '0; p = '0;
        for (int i = 0; i < BS; i++) p[i] = BSW'(i);
        send(BS, l, p, 0);
        wait_valid(n);
        check("cnt_full_inum", 192'(out_inum), 192'(BS));
        wait_idle();

        l = '0; p = '0;
        for (int i = 0; i < 5; i++) l[i] = WW'(3);
        send(5, l, p, 0);
        @(posedge clk);
        @(posedge clk); #1;
        check("t6_pre_rst_cnt", 192'(out_inum), 192'(2));
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        q.delete();
        m_cnt = 0; m_fill = 0; m_ilen = '0; m_ipos = '0; m_psum = '0;
        @(negedge clk);
        check("t6_in_ready", 192'(in_ready), 192'(1));
        check("t6_out_valid", 192'(out_valid), 192'(0));
        check("t6_inum", 192'(out_inum), 192'(0));
        check("t6_fill", 192'(out_fill), 192'(0));
        check("t6_psum", 192'(o_psum), 192'(0));
        check("t6_ilen", 192'(o_ilen), 192'(0));
        l = '0; l[0] = WW'(4);
        send(1, l, '0, 1);
        wait_idle();

        or_rand = 1;
        for (int b = 0; b < 25; b++) begin
            for (int i = 0; i < BS; i++) begin
                l[i] = WW'($urandom_range(0, (1 << WW) - 1));
                p[i] = BSW'($urandom_range(0, BS - 1));
            end
            send(int'($urandom_range(0, BS)), l, p, 1'($urandom_range(0, 1)));
        end
        send(0, '0, '0, 1);
        wait_idle();
        or_rand = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
